// File: rtl/riscv_pkg.sv
// Shared core package: opcode constants and the MEMCOPY sequencer state type.
package riscv_pkg;

    // Base RV32I major opcodes already used by the main decoder
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

    // Custom multi-cycle block-copy instruction
    localparam logic [6:0] OPC_MEMCOPY = 7'b0001000;

    // MEMCOPY sequencer states
    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_t;

endpackage

// File: rtl/memcopy_sequencer.sv
// MEMCOPY sequencer: copies len_words words from src_addr to dst_addr, one
// read followed by one write per word, through the shared data-memory port.
// The PC is held via stall until the copy has finished; done pulses for one
// cycle in the DONE state. A start that is still high when the copy finishes
// (the same instruction still being decoded) is blocked until start drops.
module memcopy_sequencer
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              stall,
    output logic              done
);

    localparam int                BYTES    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STEP     = (ADDR_W)'(BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W)'(BYTES - 1);
    localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  CNT_ZERO = {LEN_W{1'b0}};

    mc_state_t         state_r;
    mc_state_t         state_next_s;
    logic [ADDR_W-1:0] src_ptr_r;
    logic [ADDR_W-1:0] dst_ptr_r;
    logic [LEN_W-1:0]  cnt_r;
    logic [DATA_W-1:0] buf_r;
    logic              block_r;   // start held over from a finished copy
    logic              accept_s;

    // A new copy is taken only from IDLE, outside reset, with start re-armed
    assign accept_s = (state_r == MC_IDLE) && start && !block_r && !reset;

    // State, pointer, counter, data buffer and re-arm registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= MC_IDLE;
            src_ptr_r <= {ADDR_W{1'b0}};
            dst_ptr_r <= {ADDR_W{1'b0}};
            cnt_r     <= CNT_ZERO;
            buf_r     <= {DATA_W{1'b0}};
            block_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                MC_IDLE: begin
                    if (accept_s) begin
                        // Pointers are word aligned; low byte-offset bits dropped
                        src_ptr_r <= src_addr & ~LOW_MASK;
                        dst_ptr_r <= dst_addr & ~LOW_MASK;
                        cnt_r     <= len_words;
                    end
                    if (!start) begin
                        block_r <= 1'b0;
                    end
                end
                MC_READ: begin
                    buf_r <= mem_rdata;
                end
                MC_WRITE: begin
                    // Pointer wrap past the top of memory is intentional
                    src_ptr_r <= src_ptr_r + STEP;
                    dst_ptr_r <= dst_ptr_r + STEP;
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                MC_DONE: begin
                    // The instruction is still decoded here; a held start must not retrigger
                    block_r <= start;
                end
                default: begin
                    block_r <= 1'b0;
                end
            endcase
        end
    end

    // Next-state decode and memory-port / handshake outputs
    always_comb begin
        state_next_s = state_r;
        mem_addr     = {ADDR_W{1'b0}};
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = {DATA_W{1'b0}};
        busy         = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        case (state_r)
            MC_IDLE: begin
                // Stall on the decode cycle itself so the PC never moves past MEMCOPY
                stall = accept_s;
                if (accept_s) begin
                    if (len_words != CNT_ZERO) begin
                        state_next_s = MC_READ;
                    end else begin
                        state_next_s = MC_DONE;
                    end
                end else begin
                    state_next_s = MC_IDLE;
                end
            end
            MC_READ: begin
                busy         = 1'b1;
                stall        = 1'b1;
                mem_read     = 1'b1;
                mem_addr     = src_ptr_r;
                state_next_s = MC_WRITE;
            end
            MC_WRITE: begin
                busy      = 1'b1;
                stall     = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_ptr_r;
                mem_wdata = buf_r;
                // cnt_r is never zero here; <= keeps the FSM finite regardless
                if (cnt_r <= CNT_ONE) begin
                    state_next_s = MC_DONE;
                end else begin
                    state_next_s = MC_READ;
                end
            end
            MC_DONE: begin
                done         = 1'b1;
                state_next_s = MC_IDLE;
            end
            default: begin
                state_next_s = MC_IDLE;
            end
        endcase
    end

endmodule
